// File: rtl/ads1115_scan_sequencer_pkg.sv
// Shared definitions for the ADS1115 scan sequencer family: register
// pointers, config-word field positions, FSM encoding and a channel picker.
package ads1115_pkg;

   // ADS1115 register pointer bytes
   localparam logic [7:0] REG_CONV = 8'h00;
   localparam logic [7:0] REG_CFG  = 8'h01;

   // Config register field positions (MSB of each field)
   localparam int CFG_OS_BIT   = 15;
   localparam int CFG_MUX_MSB  = 14;
   localparam int CFG_PGA_MSB  = 11;
   localparam int CFG_MODE_BIT = 8;
   localparam int CFG_DR_MSB   = 7;
   localparam int CFG_COMP_MSB = 4;

   // Comparator fully disabled, ALERT/RDY pin high-impedance
   localparam logic [4:0] COMP_DISABLE = 5'b00011;

   // Sequencer states
   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_SEL   = 4'd1,
      ST_CFG   = 4'd2,
      ST_CFG_W = 4'd3,
      ST_CONV  = 4'd4,
      ST_PTR   = 4'd5,
      ST_PTR_W = 4'd6,
      ST_RD    = 4'd7,
      ST_RD_W  = 4'd8,
      ST_DONE  = 4'd9
   } state_t;

   // Index of the lowest set bit; returns 0 for an empty mask
   function automatic logic [1:0] lowest_set(input logic [3:0] mask);
      logic [1:0] ch;
      ch = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (mask[i]) ch = 2'(i);
      end
      return ch;
   endfunction

endpackage

// File: rtl/ads1115_scan_sequencer_if.sv
// Command/response bus between the scan sequencer and the I2C transaction engine.
interface ads1115_scan_sequencer_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [6:0]  cmd_addr;
   logic        cmd_rw;
   logic [7:0]  cmd_reg;
   logic [15:0] cmd_wdata;
   logic [1:0]  cmd_nbytes;
   logic        cmd_done;
   logic        cmd_nack;
   logic [15:0] rsp_data;

   // Sequencer side issues commands
   modport master (
      output cmd_valid, cmd_addr, cmd_rw, cmd_reg, cmd_wdata, cmd_nbytes,
      input  cmd_ready, cmd_done, cmd_nack, rsp_data
   );

   // Engine side executes them
   modport slave (
      input  cmd_valid, cmd_addr, cmd_rw, cmd_reg, cmd_wdata, cmd_nbytes,
      output cmd_ready, cmd_done, cmd_nack, rsp_data
   );
endinterface

// File: rtl/ads1115_scan_sequencer_cfg_word.sv
// Combinational builder of the single-shot, single-ended ADS1115 config word.
module ads1115_cfg_word
   import ads1115_pkg::*;
(
   input  logic [1:0]  i_ch,
   input  logic [2:0]  i_pga,
   input  logic [2:0]  i_dr,
   output logic [15:0] o_word
);

   // Assemble OS=1, MUX=1xx (AINx vs GND), PGA, MODE=single-shot, DR, comparator off
   always_comb begin
      o_word                      = '0;
      o_word[CFG_OS_BIT]          = 1'b1;
      o_word[CFG_MUX_MSB -: 3]    = {1'b1, i_ch};
      o_word[CFG_PGA_MSB -: 3]    = i_pga;
      o_word[CFG_MODE_BIT]        = 1'b1;
      o_word[CFG_DR_MSB -: 3]     = i_dr;
      o_word[CFG_COMP_MSB -: 5]   = COMP_DISABLE;
   end

endmodule

// File: rtl/ads1115_scan_sequencer.sv
// Scans the enabled ADS1115 single-ended inputs in ascending order:
// config write, conversion wait, pointer write, 16-bit read, per channel.
module ads1115_scan_sequencer
   import ads1115_pkg::*;
#(
   parameter logic [6:0] I2C_ADDR         = 7'h48,
   parameter logic [2:0] PGA              = 3'b001,
   parameter logic [2:0] DR               = 3'b100,
   parameter int         CONV_WAIT_CYCLES = 500_000,
   parameter int         SCAN_GAP_CYCLES  = 50_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        continuous,
   input  logic [3:0]  ch_mask,
   ads1115_scan_sequencer_if.master bus,
   output logic [63:0] results,
   output logic        result_valid,
   output logic [1:0]  result_ch,
   output logic        scan_done,
   output logic        busy,
   output logic        err_nack
);

   // One down-counter serves both the conversion wait and the inter-scan gap
   localparam int CONV_W = (CONV_WAIT_CYCLES > 1) ? $clog2(CONV_WAIT_CYCLES) : 1;
   localparam int GAP_W  = (SCAN_GAP_CYCLES > 1) ? $clog2(SCAN_GAP_CYCLES) : 1;
   localparam int CNT_W  = (CONV_W > GAP_W) ? CONV_W : GAP_W;
   localparam logic [CNT_W-1:0] CONV_LOAD = CNT_W'(CONV_WAIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(SCAN_GAP_CYCLES - 1);

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_gap_armed;
   logic [3:0]         r_mask;
   logic [1:0]         r_ch;
   logic               r_cmd_valid;
   logic [6:0]         r_cmd_addr;
   logic               r_cmd_rw;
   logic [7:0]         r_cmd_reg;
   logic [15:0]        r_cmd_wdata;
   logic [1:0]         r_cmd_nbytes;
   logic [63:0]        r_results;
   logic               r_result_valid;
   logic [1:0]         r_result_ch;
   logic               r_scan_done;
   logic               r_busy;
   logic               r_err_nack;

   logic [1:0]         w_sel_ch;
   logic [15:0]        w_cfg_word;

   assign w_sel_ch = lowest_set(r_mask);

   ads1115_cfg_word u_cfg_word (
      .i_ch   (w_sel_ch),
      .i_pga  (PGA),
      .i_dr   (DR),
      .o_word (w_cfg_word)
   );

   // Scan FSM: walks channels, drives the single outstanding engine command
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= ST_IDLE;
         r_cnt          <= '0;
         r_gap_armed    <= 1'b0;
         r_mask         <= '0;
         r_ch           <= '0;
         r_cmd_valid    <= 1'b0;
         r_cmd_addr     <= '0;
         r_cmd_rw       <= 1'b0;
         r_cmd_reg      <= '0;
         r_cmd_wdata    <= '0;
         r_cmd_nbytes   <= '0;
         r_results      <= '0;
         r_result_valid <= 1'b0;
         r_result_ch    <= '0;
         r_scan_done    <= 1'b0;
         r_busy         <= 1'b0;
         r_err_nack     <= 1'b0;
      end else begin
         r_result_valid <= 1'b0;
         r_scan_done    <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (start || (r_gap_armed && (r_cnt == '0) && continuous)) begin
                  r_mask      <= ch_mask;
                  r_busy      <= 1'b1;
                  r_gap_armed <= 1'b0;
                  r_state     <= ST_SEL;
                  if (start) r_err_nack <= 1'b0;
               end else if (r_gap_armed) begin
                  // Gap expiring with continuous low: wait for an explicit start
                  if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
                  else             r_gap_armed <= 1'b0;
               end
            end
            ST_SEL: begin
               if (r_mask == '0) begin
                  r_scan_done <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= ST_DONE;
               end else begin
                  r_ch         <= w_sel_ch;
                  r_cmd_valid  <= 1'b1;
                  r_cmd_addr   <= I2C_ADDR;
                  r_cmd_rw     <= 1'b0;
                  r_cmd_reg    <= REG_CFG;
                  r_cmd_wdata  <= w_cfg_word;
                  r_cmd_nbytes <= 2'd2;
                  r_state      <= ST_CFG;
               end
            end
            ST_CFG: begin
               if (bus.cmd_ready) begin
                  r_cmd_valid <= 1'b0;
                  r_state     <= ST_CFG_W;
               end
            end
            ST_CONV: begin
               if (r_cnt == '0) begin
                  r_cmd_valid  <= 1'b1;
                  r_cmd_addr   <= I2C_ADDR;
                  r_cmd_rw     <= 1'b0;
                  r_cmd_reg    <= REG_CONV;
                  r_cmd_wdata  <= '0;
                  r_cmd_nbytes <= 2'd0;
                  r_state      <= ST_PTR;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            ST_PTR: begin
               if (bus.cmd_ready) begin
                  r_cmd_valid <= 1'b0;
                  r_state     <= ST_PTR_W;
               end
            end
            ST_RD: begin
               if (bus.cmd_ready) begin
                  r_cmd_valid <= 1'b0;
                  r_state     <= ST_RD_W;
               end
            end
            ST_CFG_W, ST_PTR_W, ST_RD_W: begin
               if (bus.cmd_done) begin
                  if (bus.cmd_nack) begin
                     // Abandon this channel, keep its previous result, no retry
                     r_err_nack   <= 1'b1;
                     r_mask[r_ch] <= 1'b0;
                     r_state      <= ST_SEL;
                  end else if (r_state == ST_CFG_W) begin
                     r_cnt   <= CONV_LOAD;
                     r_state <= ST_CONV;
                  end else if (r_state == ST_PTR_W) begin
                     r_cmd_valid  <= 1'b1;
                     r_cmd_addr   <= I2C_ADDR;
                     r_cmd_rw     <= 1'b1;
                     r_cmd_reg    <= REG_CONV;
                     r_cmd_wdata  <= '0;
                     r_cmd_nbytes <= 2'd2;
                     r_state      <= ST_RD;
                  end else begin
                     r_results[{r_ch, 4'b0000} +: 16] <= bus.rsp_data;
                     r_result_valid <= 1'b1;
                     r_result_ch    <= r_ch;
                     r_mask[r_ch]   <= 1'b0;
                     r_state        <= ST_SEL;
                  end
               end
            end
            ST_DONE: begin
               r_cnt       <= GAP_LOAD;
               r_gap_armed <= 1'b1;
               r_state     <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.cmd_valid  = r_cmd_valid;
   assign bus.cmd_addr   = r_cmd_addr;
   assign bus.cmd_rw     = r_cmd_rw;
   assign bus.cmd_reg    = r_cmd_reg;
   assign bus.cmd_wdata  = r_cmd_wdata;
   assign bus.cmd_nbytes = r_cmd_nbytes;
   assign results        = r_results;
   assign result_valid   = r_result_valid;
   assign result_ch      = r_result_ch;
   assign scan_done      = r_scan_done;
   assign busy           = r_busy;
   assign err_nack       = r_err_nack;

endmodule
